// File: rtl/scope_frame_uploader_pkg.sv
// Shared oscilloscope host-link definitions: command decoder codes, framing constants
// and the uplink framer state encoding.
package scope_frame_uploader_pkg;

   localparam logic [1:0] GATHER_RESET  = 2'b00;
   localparam logic [1:0] GATHER_CONT   = 2'b01;
   localparam logic [1:0] GATHER_SINGLE = 2'b10;

   localparam logic TRIG_RISING  = 1'b0;
   localparam logic TRIG_FALLING = 1'b1;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_STATUS = 3'd2,
      ST_LEVEL  = 3'd3,
      ST_FETCH  = 3'd4,
      ST_LOAD   = 3'd5,
      ST_SAMPLE = 3'd6,
      ST_CSUM   = 3'd7
   } state_e;

   // Frame checksum is a plain modulo-256 sum.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   function automatic logic [7:0] status_byte(input logic [1:0] gather, input logic edge_sel);
      return {gather, edge_sel, 5'b00000};
   endfunction

endpackage

// File: rtl/scope_frame_uploader.sv
// Uplink framer: streams sync, status, trigger level, DEPTH capture samples and a
// checksum to the UART TX over a valid/ready handshake.
module scope_frame_uploader
   import scope_frame_uploader_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic [1:0]        gather_set,
   input  logic              trigger_set,
   input  logic [7:0]        trigger_level,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q;
   logic [7:0]        status_q;
   logic [7:0]        level_q;
   logic [7:0]        csum_q;
   logic [7:0]        tx_data_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              rd_en_q;
   logic              tx_valid_q;
   logic              busy_q;
   logic              frame_done_q;
   logic              abort_pending_q;

   logic              accept_s;
   logic              abort_s;
   logic              abort_exit_s;
   logic [7:0]        csum_d;

   // Handshake, abort decision and running checksum including the byte on the wire.
   always_comb begin
      accept_s     = tx_valid_q & tx_ready;
      abort_s      = abort_pending_q | (gather_set == GATHER_RESET);
      csum_d       = csum_add(csum_q, tx_data_q);
      abort_exit_s = 1'b0;
      case (state_q)
         ST_SYNC, ST_STATUS, ST_LEVEL, ST_SAMPLE, ST_CSUM: abort_exit_s = accept_s & abort_s;
         ST_FETCH, ST_LOAD:                                abort_exit_s = abort_s;
         default:                                          abort_exit_s = 1'b0;
      endcase
   end

   // Frame sequencer with registered handshake, RAM strobe and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         status_q        <= 8'h00;
         level_q         <= 8'h00;
         csum_q          <= 8'h00;
         tx_data_q       <= 8'h00;
         rd_addr_q       <= '0;
         rd_en_q         <= 1'b0;
         tx_valid_q      <= 1'b0;
         busy_q          <= 1'b0;
         frame_done_q    <= 1'b0;
         abort_pending_q <= 1'b0;
      end else if (abort_exit_s) begin
         state_q         <= ST_IDLE;
         rd_addr_q       <= '0;
         rd_en_q         <= 1'b0;
         tx_valid_q      <= 1'b0;
         busy_q          <= 1'b0;
         frame_done_q    <= 1'b0;
         abort_pending_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         // A pending abort is honoured at the next byte boundary, never mid-byte.
         if ((state_q != ST_IDLE) && (gather_set == GATHER_RESET)) begin
            abort_pending_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (frame_start && (gather_set != GATHER_RESET)) begin
                  status_q   <= status_byte(gather_set, trigger_set);
                  level_q    <= trigger_level;
                  csum_q     <= 8'h00;
                  rd_addr_q  <= '0;
                  busy_q     <= 1'b1;
                  tx_data_q  <= SYNC_BYTE;
                  tx_valid_q <= 1'b1;
                  state_q    <= ST_SYNC;
               end
            end
            ST_SYNC: begin
               if (accept_s) begin
                  tx_data_q <= status_q;
                  state_q   <= ST_STATUS;
               end
            end
            ST_STATUS: begin
               if (accept_s) begin
                  csum_q    <= csum_d;
                  tx_data_q <= level_q;
                  state_q   <= ST_LEVEL;
               end
            end
            ST_LEVEL: begin
               if (accept_s) begin
                  csum_q     <= csum_d;
                  tx_valid_q <= 1'b0;
                  rd_en_q    <= 1'b1;
                  state_q    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               rd_en_q <= 1'b0;
               state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               tx_data_q  <= rd_data;
               tx_valid_q <= 1'b1;
               state_q    <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               if (accept_s) begin
                  csum_q <= csum_d;
                  if (rd_addr_q == LAST_ADDR) begin
                     tx_data_q <= csum_d;
                     state_q   <= ST_CSUM;
                  end else begin
                     rd_addr_q  <= rd_addr_q + ADDR_W'(1);
                     tx_valid_q <= 1'b0;
                     rd_en_q    <= 1'b1;
                     state_q    <= ST_FETCH;
                  end
               end
            end
            ST_CSUM: begin
               if (accept_s) begin
                  tx_valid_q   <= 1'b0;
                  frame_done_q <= 1'b1;
                  busy_q       <= 1'b0;
                  rd_addr_q    <= '0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               tx_valid_q <= 1'b0;
               rd_en_q    <= 1'b0;
               busy_q     <= 1'b0;
               rd_addr_q  <= '0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_en      = rd_en_q;
   assign rd_addr    = rd_addr_q;
   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scope_frame_uploader.sv
// Bench for scope_frame_uploader: table of framing scenarios plus hand-written abort,
// snapshot, ignored-request and mid-frame reset sequences, checked through a byte scoreboard.
module tb_scope_frame_uploader;
   import scope_frame_uploader_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic [1:0] gather_set = GATHER_CONT;
   logic       trigger_set = TRIG_RISING;
   logic [7:0] trigger_level = 8'h00;
   logic       rd_en;
   logic [1:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic       busy;
   logic       frame_done;

   scope_frame_uploader #(.DEPTH(4), .ADDR_W(2), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .gather_set(gather_set),
      .trigger_set(trigger_set), .trigger_level(trigger_level), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] gather;
      logic       tset;
      logic [7:0] level;
      int         stall;
      logic [7:0] exp_status;
      logic [7:0] exp_csum;
   } vec_t;

   vec_t       vecs [5];
   logic [7:0] ram [4];
   logic [7:0] exp_q [$];
   int         n_checks = 0;
   int         n_pass = 0;
   int         stall_n = 0;
   int         stall_cnt = 0;
   int         bytes_seen = 0;
   int         done_cnt = 0;
   int         exp_done = 0;
   int         base;
   bit         hold_pend = 1'b0;
   bit         found;
   logic [7:0] hold_data = 8'h00;
   logic [7:0] exp_b;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Capture RAM model with one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= ram[rd_addr];
   end

   // Sink: drives tx_ready with per-byte stalls, scores accepted bytes, checks hold and pulses.
   always @(negedge clk) begin
      if (rst) begin
         stall_cnt = 0;
         hold_pend = 1'b0;
      end else begin
         if (hold_pend)
            check(tx_valid && (tx_data == hold_data), "tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, hold_data}));
         if (tx_valid) begin
            if (stall_cnt < stall_n) begin
               tx_ready = 1'b0;
               stall_cnt++;
            end else begin
               tx_ready = 1'b1;
            end
         end else begin
            tx_ready = (stall_n == 0);
            stall_cnt = 0;
         end
         if (tx_valid && tx_ready) begin
            bytes_seen++;
            stall_cnt = 0;
            hold_pend = 1'b0;
            check(busy, "busy_during_byte", 32'(busy), 32'd1);
            check(exp_q.size() > 0, "byte_expected", 32'(tx_data), 32'(exp_q.size()));
            if (exp_q.size() > 0) begin
               exp_b = exp_q.pop_front();
               check(tx_data == exp_b, "tx_byte", 32'(tx_data), 32'(exp_b));
            end
         end else begin
            hold_pend = tx_valid;
            hold_data = tx_data;
         end
         if (frame_done) begin
            done_cnt++;
            check(!busy, "busy_fall_with_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic push_frame(input logic [7:0] status, input logic [7:0] level, input logic [7:0] csum);
      exp_q.push_back(8'hA5);
      exp_q.push_back(status);
      exp_q.push_back(level);
      for (int k = 0; k < 4; k++) exp_q.push_back(ram[k]);
      exp_q.push_back(csum);
   endtask

   task automatic start_frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check(tx_valid && busy && (tx_data == 8'hA5), "sync_latency",
            32'({tx_valid, busy, tx_data}), 32'({1'b1, 1'b1, 8'hA5}));
   endtask

   task automatic wait_done(input int target);
      for (int k = 0; k < 2000; k++) begin
         @(posedge clk);
         if (done_cnt >= target) break;
      end
      check(done_cnt == target, "frame_done_count", 32'(done_cnt), 32'(target));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ram[0] = 8'h10; ram[1] = 8'h20; ram[2] = 8'h30; ram[3] = 8'h40;
      vecs[0] = '{GATHER_CONT,   TRIG_RISING,  8'h80, 0, 8'h40, 8'h60};
      vecs[1] = '{GATHER_CONT,   TRIG_RISING,  8'h80, 5, 8'h40, 8'h60};
      vecs[2] = '{GATHER_SINGLE, TRIG_FALLING, 8'h33, 2, 8'hA0, 8'h73};
      vecs[3] = '{2'b11,         TRIG_RISING,  8'hFF, 1, 8'hC0, 8'h5F};
      vecs[4] = '{GATHER_CONT,   TRIG_FALLING, 8'h00, 0, 8'h60, 8'h00};

      repeat (3) @(negedge clk);
      check({rd_en, rd_addr, tx_data, tx_valid, busy, frame_done} == 14'd0, "reset_outputs",
            32'({rd_en, rd_addr, tx_data, tx_valid, busy, frame_done}), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         gather_set = vecs[i].gather;
         trigger_set = vecs[i].tset;
         trigger_level = vecs[i].level;
         stall_n = vecs[i].stall;
         push_frame(vecs[i].exp_status, vecs[i].level, vecs[i].exp_csum);
         start_frame();
         exp_done++;
         wait_done(exp_done);
         check(exp_q.size() == 0, "frame_bytes_all_sent", 32'(exp_q.size()), 32'd0);
         @(negedge clk);
         check(!busy && !tx_valid && (rd_addr == 2'd0), "idle_after_frame",
               32'({busy, tx_valid, rd_addr}), 32'd0);
      end

      // Snapshot: host command changes during samples must not leak into this frame.
      gather_set = GATHER_CONT; trigger_set = TRIG_RISING; trigger_level = 8'h80; stall_n = 0;
      push_frame(8'h40, 8'h80, 8'h60);
      start_frame();
      exp_done++;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (rd_addr == 2'd1) found = 1'b1;
      end
      check(found, "reach_sample1_snapshot", 32'(found), 32'd1);
      gather_set = GATHER_SINGLE; trigger_set = TRIG_FALLING; trigger_level = 8'h33;
      wait_done(exp_done);
      push_frame(8'hA0, 8'h33, 8'h73);
      start_frame();
      exp_done++;
      wait_done(exp_done);
      check(exp_q.size() == 0, "snapshot_bytes", 32'(exp_q.size()), 32'd0);

      // Abort while the second sample is stalled: that byte completes, nothing follows.
      gather_set = GATHER_CONT; trigger_set = TRIG_RISING; trigger_level = 8'h80; stall_n = 5;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h40); exp_q.push_back(8'h80);
      exp_q.push_back(8'h10); exp_q.push_back(8'h20);
      start_frame();
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (tx_valid && (rd_addr == 2'd1)) found = 1'b1;
      end
      check(found, "reach_sample1_abort", 32'(found), 32'd1);
      gather_set = GATHER_RESET;
      repeat (60) @(posedge clk);
      check(done_cnt == exp_done, "abort_no_done", 32'(done_cnt), 32'(exp_done));
      check(exp_q.size() == 0, "abort_pending_byte_sent", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check(!busy && !tx_valid && !rd_en && (rd_addr == 2'd0), "abort_idle",
            32'({busy, tx_valid, rd_en, rd_addr}), 32'd0);
      gather_set = GATHER_CONT;

      // Requests while busy, and with gather reset in idle, are dropped.
      stall_n = 0;
      @(posedge clk);
      base = bytes_seen;
      push_frame(8'h40, 8'h80, 8'h60);
      start_frame();
      exp_done++;
      repeat (3) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      wait_done(exp_done);
      repeat (30) @(posedge clk);
      check(bytes_seen == base + 8, "busy_request_ignored", 32'(bytes_seen - base), 32'd8);
      check(done_cnt == exp_done, "busy_request_no_done", 32'(done_cnt), 32'(exp_done));
      gather_set = GATHER_RESET;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check(!busy && !tx_valid, "reset_gather_request", 32'({busy, tx_valid}), 32'd0);
      repeat (20) @(posedge clk);
      check(bytes_seen == base + 8, "reset_gather_no_bytes", 32'(bytes_seen - base), 32'd8);
      gather_set = GATHER_CONT;

      // Reset during LEVEL, then a clean frame.
      @(posedge clk);
      base = bytes_seen;
      push_frame(8'h40, 8'h80, 8'h60);
      start_frame();
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(posedge clk);
         if (bytes_seen >= base + 2) found = 1'b1;
      end
      check(found, "reach_level", 32'(bytes_seen - base), 32'd2);
      #1 rst = 1'b1;
      exp_q.delete();
      #1;
      check({rd_en, rd_addr, tx_data, tx_valid, busy, frame_done} == 14'd0, "midframe_reset_outputs",
            32'({rd_en, rd_addr, tx_data, tx_valid, busy, frame_done}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_frame(8'h40, 8'h80, 8'h60);
      start_frame();
      exp_done++;
      wait_done(exp_done);

      repeat (5) @(posedge clk);
      check(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check(done_cnt == exp_done, "total_frames", 32'(done_cnt), 32'(exp_done));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/scope_frame_uploader.md
# scope_frame_uploader

Uplink framer for the oscilloscope host link. It takes the host command decoder's `gather_set`, `trigger_set` and `trigger_level` outputs and one completed capture buffer. On request it streams a framed byte sequence to the UART transmitter through a valid/ready handshake: sync byte, status, trigger level, DEPTH samples read from the capture RAM, and a checksum. It sits between the capture buffer and the UART TX, mirroring the downlink command path.

## Interface
- `DEPTH`, 256: samples per frame, power of two, at least 2.
- `ADDR_W`, 8: capture RAM address width; must equal log2(DEPTH).
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

Ports:
- `clk` input 1: the block's only clock.
- `rst` input 1: asynchronous, active-high reset.
- `frame_start` input 1: one-cycle request; a capture buffer is ready.
- `gather_set` input 2: sampling mode from the command decoder (00 reset/abort, 01 continuous, 10 single).
- `trigger_set` input 1: edge select (0 rising, 1 falling).
- `trigger_level` input 8: trigger level code.
- `rd_en` output 1: capture RAM read strobe.
- `rd_addr` output ADDR_W: capture RAM read address.
- `rd_data` input 8: RAM data, valid on the cycle after `rd_en`.
- `tx_data` output 8: byte to the UART TX.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: the UART TX accepts the byte.
- `busy` output 1: a frame is in progress.
- `frame_done` output 1: one-cycle pulse when a frame completes normally.

## Operation
- Reset value of every output is 0. After reset the state is IDLE and the checksum accumulator is 0.
- A byte transfers on any cycle where `tx_valid && tx_ready`.
  - While `tx_valid=1` and `tx_ready=0`, `tx_data` holds stable.
  - `tx_valid` is never retracted before acceptance.
- IDLE:
  - `frame_start=1` with `gather_set!=00` does the following: snapshots status byte = {gather_set, trigger_set, 5'b0} and trigger_level, clears the checksum, sets `rd_addr=0`, sets `busy=1`, and goes to SYNC.
  - `frame_start` with `gather_set=00` is ignored.
- SYNC: presents SYNC_BYTE. On accept, goes to STATUS.
- STATUS: presents the status snapshot. On accept, adds it to the checksum and goes to LEVEL.
- LEVEL: presents the level snapshot. On accept, adds it to the checksum and goes to FETCH.
- FETCH: asserts `rd_en` for one cycle at `rd_addr`, then goes to LOAD.
- LOAD: registers `rd_data` into `tx_data`, sets `tx_valid`, and goes to SAMPLE.
- SAMPLE: on accept, adds the byte to the checksum.
  - If `rd_addr==DEPTH-1`, goes to CSUM.
  - Otherwise increments `rd_addr` and goes to FETCH.
- CSUM: presents the checksum. On accept, pulses `frame_done`, clears `busy`, returns `rd_addr` to 0 and goes to IDLE.
- Checksum: 8-bit sum modulo 256 over the status byte, the level byte and all samples. SYNC is excluded.
- `frame_start` while `busy=1` is ignored; it is not queued.
- Snapshotted status and level do not change mid-frame, even if the host changes commands.
- Abort: `gather_set==00` sampled in any non-IDLE state sets `abort_pending`.
  - In FETCH or LOAD, the block goes to IDLE next cycle. `tx_valid` is not asserted in these states.
  - In a byte-presenting state, it goes to IDLE on that byte's accept.
  - An aborted frame gives no `frame_done`. `busy` and `rd_addr` clear on IDLE entry.
- Asserting `rst` mid-frame forces all outputs to 0 immediately. A partial frame is never resumed.

## Timing
- From `frame_start` to the first `tx_valid` (SYNC): 1 cycle.
- Each byte: `tx_valid` rises the cycle after the previous accept. Sample bytes take 2 extra cycles (FETCH, LOAD).
- RAM read latency is exactly 1 cycle. `rd_en` is asserted only in FETCH.
- `frame_done` rises the cycle after the CSUM accept, together with `busy` falling.
- A new `frame_start` is honoured from the first IDLE cycle onward.

## Structure
- The shared scope package holds:
  - the `gather_set` codes (GATHER_RESET 2'b00, GATHER_CONT 2'b01, GATHER_SINGLE 2'b10), shared with the command decoder;
  - the trigger edge codes;
  - the SYNC_BYTE default;
  - the state enum (IDLE, SYNC, STATUS, LEVEL, FETCH, LOAD, SAMPLE, CSUM).
- Implemented as a single module with no sub-modules. The checksum is inline accumulation.

## Test plan
- Normal frame: DEPTH=4, RAM = 10,20,30,40 (hex), `gather_set=01`, `trigger_set=0`, level 80, `tx_ready` tied 1 -> bytes A5,40,80,10,20,30,40,60; one `frame_done` pulse; `busy` high throughout the frame.
- Backpressure: same frame with `tx_ready` low 5 cycles per byte -> identical byte sequence; `tx_data` stable while stalled; no duplicated or dropped bytes.
- Snapshot: change to `gather_set=10`, `trigger_set=1`, level 33 during the SAMPLE states -> frame still carries 40,80; the next frame carries A0,33.
- Abort: drive `gather_set=00` while SAMPLE (addr 1) is stalled -> the pending byte completes on ready; no further bytes; `busy` 0; no `frame_done`.
- Ignored request: `frame_start` while busy, and `frame_start` with `gather_set=00` in IDLE -> no extra frame is emitted.
- Reset mid-frame: assert `rst` during LEVEL -> all outputs 0 that cycle; after release, `frame_start` produces a full, correct frame.
